// File: rtl/led_status_monitor.sv
// Board LED status stage: heartbeat, synchronized system-reset level, and
// pulse-stretched UART rx/tx activity. Define LED_PWM_EN for PWM dimming.

module led_stretch #(
  parameter int STRETCH_CYCLES = 480000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_sample,
  output logic o_led
);
  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);

  logic          r_hist;
  logic [CW-1:0] r_cnt;
  logic          r_led;
  logic          w_edge;
  logic [CW-1:0] w_cnt_nxt;

  assign w_edge = i_sample ^ r_hist;

  // A new edge always reloads, even when the count is about to expire.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_edge)              w_cnt_nxt = LOAD;
    else if (r_cnt != '0)    w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= 1'b1;
      r_cnt  <= '0;
      r_led  <= 1'b0;
    end else begin
      r_hist <= i_sample;
      r_cnt  <= w_cnt_nxt;
      r_led  <= (r_cnt != '0);
    end
  end

  assign o_led = r_led;
endmodule

module led_status_monitor #(
  parameter int HEARTBEAT_DIV  = 12000000,
  parameter int STRETCH_CYCLES = 480000,
  parameter int PWM_BITS       = 4,
  parameter int PWM_DUTY       = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sys_reset_i,
  input  logic       uart_rx_i,
  input  logic       uart_tx_i,
  output logic [3:0] led_o
);
  localparam int HB_W = $clog2(HEARTBEAT_DIV + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_DIV - 1);

  if (HEARTBEAT_DIV < 2 || STRETCH_CYCLES < 1 || PWM_BITS < 1 ||
      PWM_DUTY < 0 || PWM_DUTY > (1 << PWM_BITS)) begin : g_param_chk
    $error("led_status_monitor: parameter out of range");
  end

  logic [1:0]      r_rst_sync;
  logic [1:0]      r_rx_sync;
  logic [HB_W-1:0] r_hb_cnt;
  logic            r_hb_led;
  logic            r_rst_led;
  logic            w_rst_s;
  logic            w_rx_s;
  logic [1:0]      w_act_in;
  logic [1:0]      w_act_led;
  logic [3:0]      w_led;

  assign w_rst_s = r_rst_sync[1];
  assign w_rx_s  = r_rx_sync[1];

  // Synchronizers reset to the idle/asserted level so release creates no edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b11;
      r_rx_sync  <= 2'b11;
      r_rst_led  <= 1'b0;
      r_hb_cnt   <= '0;
      r_hb_led   <= 1'b0;
    end else begin
      r_rst_sync <= {r_rst_sync[0], sys_reset_i};
      r_rx_sync  <= {r_rx_sync[0], uart_rx_i};
      r_rst_led  <= w_rst_s;
      if (w_rst_s) begin
        r_hb_cnt <= '0;
        r_hb_led <= 1'b0;
      end else if (r_hb_cnt == HB_LAST) begin
        r_hb_cnt <= '0;
        r_hb_led <= ~r_hb_led;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
    end
  end

  // tx is already in this clock domain, so it feeds its stretcher directly.
  assign w_act_in = {uart_tx_i, w_rx_s};

  led_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_act [1:0] (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_sample (w_act_in),
    .o_led    (w_act_led)
  );

  assign w_led = {w_act_led, r_rst_led, r_hb_led};

`ifdef LED_PWM_EN
  localparam logic [PWM_BITS:0] DUTY = (PWM_BITS + 1)'(PWM_DUTY);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [3:0]          r_led_o;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_led_o   <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led_o   <= w_led & {4{({1'b0, r_pwm_cnt} < DUTY)}};
    end
  end

  assign led_o = r_led_o;
`else
  assign led_o = w_led;
`endif
endmodule
